// File: rtl/ym3438_bus_master.sv
// Register-write bus master for the YM3438: optional busy poll, then address
// and data write strobes with programmable pulse/recovery timing.
module ym3438_bus_master #(
  parameter int PULSE   = 4,
  parameter int RECOVER = 4,
  parameter int POLL    = 1,
  parameter int TIMEOUT = 255
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_bank,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       done,
  output logic       timeout_err,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic [1:0] ADDRESS,
  output logic [7:0] DATA_o,
  output logic       DATA_oe,
  input  logic [7:0] DATA_i
);

  typedef enum logic [2:0] {
    IDLE, POLL_STB, POLL_REC, AWR_STB, AWR_REC, DWR_STB, DWR_REC
  } state_t;

  localparam logic [3:0] LP_STB_LAST = 4'(PULSE - 1);
  localparam logic [3:0] LP_REC_LAST = 4'(RECOVER - 1);
  localparam logic [7:0] LP_TMO      = 8'(TIMEOUT);

  state_t     r_state, w_state_nx;
  logic [3:0] r_phase, w_phase_nx;
  logic [7:0] r_polls, w_polls_nx;
  logic       r_busy, w_busy_nx;
  logic       r_bank, w_bank_nx;
  logic [7:0] r_addr, w_addr_nx;
  logic [7:0] r_data, w_data_nx;

  logic       r_ready, w_ready_nx;
  logic       r_done, w_done_nx;
  logic       r_tmo, w_tmo_nx;
  logic       r_cs, w_cs_nx;
  logic       r_wr, w_wr_nx;
  logic       r_rd, w_rd_nx;
  logic [1:0] r_address, w_address_nx;
  logic [7:0] r_data_o, w_data_o_nx;
  logic       r_oe, w_oe_nx;

  logic       w_accept, w_stb_end, w_rec_end;
  logic       w_unused;

  // Only the busy flag of the status byte matters here.
  assign w_unused = ^DATA_i[6:0];

  always_comb begin
    w_accept   = req_valid & r_ready;
    w_stb_end  = (r_phase == LP_STB_LAST);
    w_rec_end  = (r_phase == LP_REC_LAST);
    w_state_nx = r_state;
    w_phase_nx = r_phase + 4'd1;
    w_polls_nx = r_polls;
    w_busy_nx  = r_busy;
    w_bank_nx  = r_bank;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    w_ready_nx = 1'b0;
    w_tmo_nx   = 1'b0;
    case (r_state)
      IDLE: begin
        w_phase_nx = 4'd0;
        w_ready_nx = 1'b1;
        if (w_accept) begin
          w_ready_nx = 1'b0;
          w_bank_nx  = req_bank;
          w_addr_nx  = req_addr;
          w_data_nx  = req_data;
          w_polls_nx = 8'd0;
          w_state_nx = (POLL != 0) ? POLL_STB : AWR_STB;
        end
      end
      POLL_STB: if (w_stb_end) begin
        w_busy_nx  = DATA_i[7];
        w_polls_nx = r_polls + 8'd1;
        w_phase_nx = 4'd0;
        w_state_nx = POLL_REC;
      end
      POLL_REC: if (w_rec_end) begin
        w_phase_nx = 4'd0;
        if (!r_busy) w_state_nx = AWR_STB;
        else if (r_polls < LP_TMO) w_state_nx = POLL_STB;
        else begin
          // Give up waiting and write anyway; the error pulse flags it.
          w_tmo_nx   = 1'b1;
          w_state_nx = AWR_STB;
        end
      end
      AWR_STB: if (w_stb_end) begin w_phase_nx = 4'd0; w_state_nx = AWR_REC; end
      AWR_REC: if (w_rec_end) begin w_phase_nx = 4'd0; w_state_nx = DWR_STB; end
      DWR_STB: if (w_stb_end) begin w_phase_nx = 4'd0; w_state_nx = DWR_REC; end
      DWR_REC: if (w_rec_end) begin
        w_phase_nx = 4'd0;
        w_ready_nx = 1'b1;
        w_state_nx = IDLE;
      end
      default: begin w_phase_nx = 4'd0; w_state_nx = IDLE; end
    endcase
  end

  // Bus outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_cs_nx      = 1'b1;
    w_wr_nx      = 1'b1;
    w_rd_nx      = 1'b1;
    w_oe_nx      = 1'b0;
    w_address_nx = r_address;
    w_data_o_nx  = r_data_o;
    case (w_state_nx)
      POLL_STB: begin w_cs_nx = 1'b0; w_rd_nx = 1'b0; w_address_nx = 2'b00; end
      AWR_STB: begin
        w_cs_nx = 1'b0; w_wr_nx = 1'b0; w_oe_nx = 1'b1;
        w_address_nx = {w_bank_nx, 1'b0};
        w_data_o_nx  = w_addr_nx;
      end
      DWR_STB: begin
        w_cs_nx = 1'b0; w_wr_nx = 1'b0; w_oe_nx = 1'b1;
        w_address_nx = {w_bank_nx, 1'b1};
        w_data_o_nx  = w_data_nx;
      end
      AWR_REC, DWR_REC: w_oe_nx = 1'b1;
      default: ;
    endcase
    w_done_nx = (w_state_nx == DWR_REC) && (w_phase_nx == LP_REC_LAST);
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_phase   <= 4'd0;
      r_polls   <= 8'd0;
      r_busy    <= 1'b0;
      r_bank    <= 1'b0;
      r_addr    <= 8'd0;
      r_data    <= 8'd0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_tmo     <= 1'b0;
      r_cs      <= 1'b1;
      r_wr      <= 1'b1;
      r_rd      <= 1'b1;
      r_address <= 2'b00;
      r_data_o  <= 8'd0;
      r_oe      <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_phase   <= w_phase_nx;
      r_polls   <= w_polls_nx;
      r_busy    <= w_busy_nx;
      r_bank    <= w_bank_nx;
      r_addr    <= w_addr_nx;
      r_data    <= w_data_nx;
      r_ready   <= w_ready_nx;
      r_done    <= w_done_nx;
      r_tmo     <= w_tmo_nx;
      r_cs      <= w_cs_nx;
      r_wr      <= w_wr_nx;
      r_rd      <= w_rd_nx;
      r_address <= w_address_nx;
      r_data_o  <= w_data_o_nx;
      r_oe      <= w_oe_nx;
    end
  end

  assign req_ready   = r_ready;
  assign done        = r_done;
  assign timeout_err = r_tmo;
  assign CS          = r_cs;
  assign WR          = r_wr;
  assign RD          = r_rd;
  assign ADDRESS     = r_address;
  assign DATA_o      = r_data_o;
  assign DATA_oe     = r_oe;

endmodule

// File: tb/tb_ym3438_bus_master.sv
// Directed bench: instance A has polling off, instance B polls with TIMEOUT=3.
module tb_ym3438_bus_master;
  logic MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  logic rst_a, vld_a, rdy_a, bank_a, done_a, to_a, cs_a, wr_a, rd_a, oe_a;
  logic [7:0] addr_a, data_a, do_a, di_a;
  logic [1:0] ad_a;
  logic rst_b, vld_b, rdy_b, bank_b, done_b, to_b, cs_b, wr_b, rd_b, oe_b;
  logic [7:0] addr_b, data_b, do_b, di_b;
  logic [1:0] ad_b;

  ym3438_bus_master #(.PULSE(4), .RECOVER(4), .POLL(0), .TIMEOUT(255)) u_a (
    .MCLK(MCLK), .RESET(rst_a), .req_valid(vld_a), .req_ready(rdy_a),
    .req_bank(bank_a), .req_addr(addr_a), .req_data(data_a), .done(done_a),
    .timeout_err(to_a), .CS(cs_a), .WR(wr_a), .RD(rd_a), .ADDRESS(ad_a),
    .DATA_o(do_a), .DATA_oe(oe_a), .DATA_i(di_a));

  ym3438_bus_master #(.PULSE(4), .RECOVER(4), .POLL(1), .TIMEOUT(3)) u_b (
    .MCLK(MCLK), .RESET(rst_b), .req_valid(vld_b), .req_ready(rdy_b),
    .req_bank(bank_b), .req_addr(addr_b), .req_data(data_b), .done(done_b),
    .timeout_err(to_b), .CS(cs_b), .WR(wr_b), .RD(rd_b), .ADDRESS(ad_b),
    .DATA_o(do_b), .DATA_oe(oe_b), .DATA_i(di_b));

  int checks = 0, failures = 0;
  int busy_polls = 0, poll_base = 0;

  // Strobe monitors, sampled on the falling edge.
  int a_wr_n = 0, a_done_n = 0;
  int b_wr_n = 0, b_rd_n = 0, b_done_n = 0, b_to_n = 0, b_rd_bad = 0, strobe_bad = 0;
  logic a_wr_q = 1'b1, b_wr_q = 1'b1, b_rd_q = 1'b1;
  logic [47:0] a_wlog = '0;
  logic [15:0] b_dlog = '0;
  logic [3:0]  b_adlog = '0;
  logic bad_a, bad_b;

  assign di_a = 8'h00;
  assign di_b = ((b_rd_n - poll_base) <= busy_polls) ? 8'h80 : 8'h00;
  assign bad_a = (!cs_a && (wr_a == rd_a)) || (!wr_a && !rd_a) || (cs_a && (!wr_a || !rd_a));
  assign bad_b = (!cs_b && (wr_b == rd_b)) || (!wr_b && !rd_b) || (cs_b && (!wr_b || !rd_b));

  always @(negedge MCLK) begin
    a_wr_q <= wr_a; b_wr_q <= wr_b; b_rd_q <= rd_b;
    if (!rst_a && !rst_b) strobe_bad <= strobe_bad + (bad_a ? 1 : 0) + (bad_b ? 1 : 0);
    if (!rst_a) begin
      if (!wr_a && a_wr_q) begin a_wr_n <= a_wr_n + 1; a_wlog <= {a_wlog[39:0], do_a}; end
      if (done_a) a_done_n <= a_done_n + 1;
    end
    if (!rst_b) begin
      if (!wr_b && b_wr_q) begin
        b_wr_n <= b_wr_n + 1; b_dlog <= {b_dlog[7:0], do_b}; b_adlog <= {b_adlog[1:0], ad_b};
      end
      if (!rd_b && b_rd_q) b_rd_n <= b_rd_n + 1;
      if (!rd_b && ad_b != 2'b00) b_rd_bad <= b_rd_bad + 1;
      if (done_b) b_done_n <= b_done_n + 1;
      if (to_b) b_to_n <= b_to_n + 1;
    end
  end

  task automatic tick;
    @(posedge MCLK); #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) tick();
    checks++;
    if ({cs_a, wr_a, rd_a, oe_a, ad_a, do_a, done_a, to_a, rdy_a} !== 17'b1110_00_00000000_000) begin
      failures++; $display("FAIL reset_a got=%b want=%b", {cs_a, wr_a, rd_a, oe_a, ad_a, do_a, done_a, to_a, rdy_a}, 17'b1110_00_00000000_000);
    end
    checks++;
    if ({cs_b, wr_b, rd_b, oe_b, ad_b, do_b, done_b, to_b, rdy_b} !== 17'b1110_00_00000000_000) begin
      failures++; $display("FAIL reset_b got=%b want=%b", {cs_b, wr_b, rd_b, oe_b, ad_b, do_b, done_b, to_b, rdy_b}, 17'b1110_00_00000000_000);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    checks++;
    if ({rdy_a, rdy_b} !== 2'b11) begin
      failures++; $display("FAIL ready_after_reset got=%b want=11", {rdy_a, rdy_b});
    end
  endtask

  task automatic test_write_a;
    logic [15:0] exp, got;
    checks++;
    if (rdy_a !== 1'b1) begin failures++; $display("FAIL write_a_ready got=%b want=1", rdy_a); end
    bank_a = 1'b0; addr_a = 8'h28; data_a = 8'hF0; vld_a = 1'b1;
    tick();
    vld_a = 1'b0; addr_a = 8'hEE; data_a = 8'hEE; bank_a = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      if (k <= 4)       exp = {3'b001, 2'b00, 8'h28, 3'b100};
      else if (k <= 8)  exp = {3'b111, 2'b00, 8'h28, 3'b100};
      else if (k <= 12) exp = {3'b001, 2'b01, 8'hF0, 3'b100};
      else if (k <= 16) exp = {3'b111, 2'b01, 8'hF0, 1'b1, (k == 16), 1'b0};
      else              exp = {3'b111, 2'b01, 8'hF0, 3'b001};
      got = {cs_a, wr_a, rd_a, ad_a, do_a, oe_a, done_a, rdy_a};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL write_a_cycle%0d got=%h want=%h", k, got, exp); end
      tick();
    end
  endtask

  task automatic run_poll_b(input int busy, input int want_to);
    int k, rd0, wr0, to0, dn0, bad0;
    rd0 = b_rd_n; wr0 = b_wr_n; to0 = b_to_n; dn0 = b_done_n; bad0 = b_rd_bad;
    poll_base = b_rd_n; busy_polls = busy;
    bank_b = 1'b1; addr_b = 8'h30; data_b = 8'h71; vld_b = 1'b1;
    tick();
    vld_b = 1'b0; addr_b = 8'hEE; data_b = 8'hEE;
    k = 1;
    while (done_b !== 1'b1 && k < 200) begin tick(); k++; end
    checks++;
    if (done_b !== 1'b1 || k != 40) begin failures++; $display("FAIL poll_latency got=%0d want=40", k); end
    tick();
    checks++;
    if (b_rd_n - rd0 != 3) begin failures++; $display("FAIL poll_count got=%0d want=3", b_rd_n - rd0); end
    checks++;
    if (b_wr_n - wr0 != 2) begin failures++; $display("FAIL poll_writes got=%0d want=2", b_wr_n - wr0); end
    checks++;
    if (b_to_n - to0 != want_to) begin failures++; $display("FAIL poll_timeout got=%0d want=%0d", b_to_n - to0, want_to); end
    checks++;
    if (b_done_n - dn0 != 1) begin failures++; $display("FAIL poll_done got=%0d want=1", b_done_n - dn0); end
    checks++;
    if ({b_adlog, b_dlog} !== {4'b1011, 16'h3071}) begin
      failures++; $display("FAIL poll_bus got=%h want=%h", {b_adlog, b_dlog}, {4'b1011, 16'h3071});
    end
    checks++;
    if (b_rd_bad != bad0) begin failures++; $display("FAIL poll_rd_address got=%0d want=%0d", b_rd_bad, bad0); end
  endtask

  task automatic test_poll_b;
    run_poll_b(2, 0);
  endtask

  task automatic test_timeout_b;
    run_poll_b(1000, 1);
  endtask

  task automatic test_back_to_back;
    int i, cyc, wr0, dn0;
    int acc [3];
    i = 0; cyc = 0; wr0 = a_wr_n; dn0 = a_done_n;
    while (i < 3 && cyc < 200) begin
      if (rdy_a === 1'b1) begin
        bank_a = 1'b0; addr_a = 8'hA0 + 8'(i); data_a = 8'h10 + 8'(i); acc[i] = cyc; i++;
      end else begin
        bank_a = 1'b1; addr_a = 8'hEE; data_a = 8'hEE;
      end
      vld_a = 1'b1;
      tick(); cyc++;
    end
    vld_a = 1'b0;
    while (a_done_n - dn0 < 3 && cyc < 300) begin tick(); cyc++; end
    tick();
    checks++;
    if (i != 3) begin failures++; $display("FAIL b2b_accepts got=%0d want=3", i); end
    checks++;
    if (acc[1] - acc[0] != 17 || acc[2] - acc[1] != 17) begin
      failures++; $display("FAIL b2b_gap got=%0d,%0d want=17,17", acc[1] - acc[0], acc[2] - acc[1]);
    end
    checks++;
    if (a_wr_n - wr0 != 6 || a_done_n - dn0 != 3) begin
      failures++; $display("FAIL b2b_counts got wr=%0d done=%0d want wr=6 done=3", a_wr_n - wr0, a_done_n - dn0);
    end
    checks++;
    if (a_wlog !== 48'hA010A111A212) begin failures++; $display("FAIL b2b_data got=%h want=%h", a_wlog, 48'hA010A111A212); end
  endtask

  task automatic test_reset_mid;
    int k, dn0;
    bank_a = 1'b0; addr_a = 8'h2A; data_a = 8'h55; vld_a = 1'b1;
    tick();
    vld_a = 1'b0;
    tick();
    dn0 = a_done_n;
    rst_a = 1'b1;
    tick();
    checks++;
    if ({cs_a, wr_a, rd_a, oe_a, rdy_a, done_a} !== 6'b111000) begin
      failures++; $display("FAIL mid_reset got=%b want=111000", {cs_a, wr_a, rd_a, oe_a, rdy_a, done_a});
    end
    rst_a = 1'b0;
    repeat (20) tick();
    checks++;
    if (a_done_n != dn0 || rdy_a !== 1'b1) begin
      failures++; $display("FAIL mid_reset_idle got done=%0d ready=%b want done=%0d ready=1", a_done_n, rdy_a, dn0);
    end
    bank_a = 1'b1; addr_a = 8'h2B; data_a = 8'h66; vld_a = 1'b1;
    tick();
    vld_a = 1'b0;
    k = 1;
    while (done_a !== 1'b1 && k < 100) begin tick(); k++; end
    checks++;
    if (done_a !== 1'b1 || k != 16) begin failures++; $display("FAIL mid_reset_retry_latency got=%0d want=16", k); end
    checks++;
    if (ad_a !== 2'b11) begin failures++; $display("FAIL mid_reset_retry_port got=%b want=11", ad_a); end
    tick();
    checks++;
    if (a_wlog[15:0] !== 16'h2B66) begin failures++; $display("FAIL mid_reset_retry_data got=%h want=2b66", a_wlog[15:0]); end
  endtask

  initial begin
    vld_a = 1'b0; bank_a = 1'b0; addr_a = 8'h00; data_a = 8'h00;
    vld_b = 1'b0; bank_b = 1'b0; addr_b = 8'h00; data_b = 8'h00;
    rst_a = 1'b1; rst_b = 1'b1;
    test_reset();
    test_write_a();
    test_poll_b();
    test_timeout_b();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (strobe_bad != 0) begin failures++; $display("FAIL strobe_rules got=%0d want=0", strobe_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
